// File: rtl/isa_pkg.sv
// Shared ISA field positions, opcode values and fetch/decode buffer state encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package isa_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;
    localparam int IMM_HI = 23;
    localparam int IMM_LO = 0;

    localparam logic [OPC_W-1:0] ANDI = 6'h0C;
    localparam logic [OPC_W-1:0] ORI  = 6'h0D;
    localparam logic [OPC_W-1:0] XORI = 6'h0E;
    localparam logic [OPC_W-1:0] LUI  = 6'h0F;

    // Defined opcodes are a base block 0x00..BASE_MAX plus an extended block EXT_LO..EXT_HI.
    localparam logic [OPC_W-1:0] OPC_BASE_MAX = 6'h0F;
    localparam logic [OPC_W-1:0] OPC_EXT_LO   = 6'h20;
    localparam logic [OPC_W-1:0] OPC_EXT_HI   = 6'h27;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic logic opc_defined(input logic [OPC_W-1:0] opc);
        return (opc <= OPC_BASE_MAX) || ((opc >= OPC_EXT_LO) && (opc <= OPC_EXT_HI));
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Opcode decode: sign-extension control for the immediate and illegal-opcode flag.
// Latency: combinational.
// Backpressure: none; pure function of the opcode.
module instr_field_decode
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             signop,
    output logic             illegal
);

    always_comb begin
        signop  = !(opcode inside {ANDI, ORI, XORI, LUI});
        illegal = !opc_defined(opcode);
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch->decode stage: 2-entry skid buffer holding {instr, pc, signop, illegal}.
// Latency: 1 cycle in-fire to out_valid; 1 instruction/cycle sustained.
// Backpressure: in_ready registered, drops only when both main and skid are occupied.
module fetch_decode_buffer
    import isa_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int IMM_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_signop,
    output logic               out_illegal
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               signop;
        logic               illegal;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     main_q, main_d, skid_q, skid_d, in_entry;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       in_fire, out_fire;
    logic       in_signop, in_illegal;

    // Decode once on the way in so decode sees flop outputs, not a logic cone.
    instr_field_decode u_field_decode (
        .opcode  (in_instr[OPC_HI:OPC_LO]),
        .signop  (in_signop),
        .illegal (in_illegal)
    );

    always_comb begin
        in_entry = '{instr: in_instr, pc: in_pc, signop: in_signop, illegal: in_illegal};
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_entry;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.instr[IMM_LO +: IMM_W];
    assign out_signop  = main_q.signop;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer; inputs driven and outputs
// sampled on the falling edge, away from the rising active edge.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [23:0] out_imm;
    logic        out_signop;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_decode_buffer #(.INSTR_W(32), .PC_W(32), .IMM_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_signop  (out_signop),
        .out_illegal (out_illegal)
    );

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h0000_1234;
        repeat (3) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        tests++; if (out_imm !== 24'h0) begin fails++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        tests++; if ({out_signop, out_illegal} !== 2'b00) begin fails++; $display("FAIL reset_sign_ill got %b want 00", {out_signop, out_illegal}); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_no_capture got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] instrs [4];
        logic [31:0] pcs [4];
        instrs[0] = 32'h0480_0010; instrs[1] = 32'h3400_0005;
        instrs[2] = 32'h8000_0001; instrs[3] = 32'h4C00_0ABC;
        for (int i = 0; i < 4; i++) pcs[i] = 32'h0000_0100 + 32'(4 * i);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = instrs[i]; in_pc = pcs[i];
            @(negedge clk);
            tests++; if (out_valid !== 1'b1 || out_instr !== instrs[i] || out_pc !== pcs[i] || in_ready !== 1'b1)
                begin fails++; $display("FAIL stream_%0d got v=%b instr=%h pc=%h rdy=%b want v=1 instr=%h pc=%h rdy=1", i, out_valid, out_instr, out_pc, in_ready, instrs[i], pcs[i]); end
            if (i == 0) begin
                tests++; if (out_imm !== 24'h80_0010 || out_signop !== 1'b1 || out_illegal !== 1'b0)
                    begin fails++; $display("FAIL stream_first_fields got imm=%h s=%b ill=%b want imm=800010 s=1 ill=0", out_imm, out_signop, out_illegal); end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h2000_00AA; in_pc = 32'h0000_0200;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h2000_00AA || in_ready !== 1'b1)
            begin fails++; $display("FAIL bp_one got v=%b instr=%h rdy=%b want v=1 instr=200000aa rdy=1", out_valid, out_instr, in_ready); end
        in_instr = 32'h3800_00BB; in_pc = 32'h0000_0204;
        @(negedge clk);
        tests++; if (in_ready !== 1'b0 || out_instr !== 32'h2000_00AA || out_pc !== 32'h0000_0200)
            begin fails++; $display("FAIL bp_full got rdy=%b instr=%h pc=%h want rdy=0 instr=200000aa pc=200", in_ready, out_instr, out_pc); end
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h2000_00AA || in_ready !== 1'b0)
            begin fails++; $display("FAIL bp_hold got v=%b instr=%h rdy=%b want v=1 instr=200000aa rdy=0", out_valid, out_instr, in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h3800_00BB || out_pc !== 32'h0000_0204 || out_signop !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL bp_second got v=%b instr=%h pc=%h s=%b rdy=%b want v=1 instr=380000bb pc=204 s=0 rdy=1", out_valid, out_instr, out_pc, out_signop, in_ready); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_signop();
        logic [31:0] instrs [7];
        logic [1:0]  exp [7];
        instrs[0] = 32'h34FF_FFFF; exp[0] = 2'b00;
        instrs[1] = 32'h20FF_FFFF; exp[1] = 2'b10;
        instrs[2] = 32'hFC00_0000; exp[2] = 2'b11;
        instrs[3] = 32'h3C12_3456; exp[3] = 2'b00;
        instrs[4] = 32'h9C00_0000; exp[4] = 2'b10;
        instrs[5] = 32'hA000_0000; exp[5] = 2'b11;
        instrs[6] = 32'h4000_0000; exp[6] = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_instr = instrs[i]; in_pc = 32'h0000_0300;
            @(negedge clk);
            tests++; if ({out_signop, out_illegal} !== exp[i] || out_imm !== instrs[i][23:0] || out_valid !== 1'b1)
                begin fails++; $display("FAIL signop_%0d got s/ill=%b imm=%h v=%b want s/ill=%b imm=%h v=1", i, {out_signop, out_illegal}, out_imm, out_valid, exp[i], instrs[i][23:0]); end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit seen_bad = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_0A01; in_pc = 32'h0000_0400;
        @(negedge clk);
        in_instr = 32'h0000_0B02; in_pc = 32'h0000_0404;
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_prefull got rdy=%b want 0", in_ready); end
        flush = 1'b1; in_instr = 32'h0000_0C03; in_pc = 32'h0000_0408;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL flush_full got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        // Flush in ONE while an input fires: that input must be dropped too.
        flush = 1'b0; in_instr = 32'h0000_0D04; in_pc = 32'h0000_040C;
        @(negedge clk);
        flush = 1'b1; in_instr = 32'h0000_0E05; in_pc = 32'h0000_0410;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL flush_one got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_bad = 1'b1;
        end
        tests++; if (seen_bad) begin fails++; $display("FAIL flush_no_leak got stale out_valid=1 want 0"); end
        in_valid = 1'b1; in_instr = 32'h0000_0F06; in_pc = 32'h0000_0414;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_0F06 || out_pc !== 32'h0000_0414)
            begin fails++; $display("FAIL flush_after got v=%b instr=%h pc=%h want v=1 instr=00000f06 pc=414", out_valid, out_instr, out_pc); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0400_1111; in_pc = 32'h0000_0500;
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL areset_pre got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_pc !== 32'h0)
            begin fails++; $display("FAIL areset_immediate got v=%b rdy=%b instr=%h pc=%h want v=0 rdy=1 instr=0 pc=0", out_valid, in_ready, out_instr, out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_after got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_signop();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
